// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer.
//
// Owns the PC and drives the instruction memory address. The memory read is
// combinational, so the returned word is captured into a one-entry
// valid/ready output stage toward decode. The block handles start, halt,
// redirect (branch/jump) and back-pressure from decode.
//
// Optional feature: define FETCH_BOUNDS_CHECK_EN to enable the out-of-range
// fetch check. A load whose word index (pc_q>>2) is >= MEM_WORDS is
// suppressed, fault_o is set (sticky until rst) and the sequencer halts.
// Without the macro fault_o is constant 0.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start_i         leave IDLE/HALTED and begin fetching
//   halt_i          stop issuing new fetches
//   redirect_i      load redirect_pc_i into the PC and flush the output stage
//   redirect_pc_i   target byte address (low two bits ignored)
//   imem_addr_o     byte address to instruction memory (= PC)
//   imem_rdata_i    instruction word for imem_addr_o, same cycle
//   inst_o, pc_o    registered instruction and its byte address
//   valid_o/ready_i output handshake toward decode
//   busy_o          high while in RUN
//   fetch_cnt_o     number of handoffs (valid_o && ready_i), wraps
//   fault_o         sticky out-of-range fault
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 301,
  parameter logic [31:0] PC_STEP   = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        halt_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        busy_o,
  output logic [31:0] fetch_cnt_o,
  output logic        fault_o
);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] RUN    = 2'b01;
  localparam logic [1:0] HALTED = 2'b10;

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

  logic [1:0]  state_q;
  logic [31:0] pc_q;
  logic        fault_q;

  logic        hand;
  logic        load_req;
  logic        oob;
  logic        load;

  // Redirect targets are word aligned; low address bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  assign imem_addr_o = pc_q;
  assign busy_o      = (state_q == RUN);
  assign fault_o     = BOUNDS_EN ? fault_q : 1'b0;

  assign hand     = valid_o && ready_i;
  // A load is wanted only when nothing of higher priority happens this cycle
  // and the output slot is empty or being emptied.
  assign load_req = (state_q == RUN) && !redirect_i && !halt_i &&
                    (!valid_o || ready_i);
  assign oob      = BOUNDS_EN && load_req && ((pc_q >> 2) >= MEM_WORDS_W);
  assign load     = load_req && !oob;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      valid_o     <= 1'b0;
      inst_o      <= 32'h0;
      pc_o        <= 32'h0;
      fetch_cnt_o <= 32'h0;
      fault_q     <= 1'b0;
    end else begin
      // The counter sees the handoff even when a redirect flushes the slot.
      if (hand) fetch_cnt_o <= fetch_cnt_o + 32'd1;

      if (redirect_i) begin
        pc_q    <= align_pc(redirect_pc_i);
        valid_o <= 1'b0;
      end else if (load) begin
        inst_o  <= imem_rdata_i;
        pc_o    <= pc_q;
        valid_o <= 1'b1;
        pc_q    <= pc_q + PC_STEP;
      end else if (hand) begin
        valid_o <= 1'b0;
      end

      if (oob) fault_q <= 1'b1;

      case (state_q)
        IDLE:    if (start_i && !fault_q) state_q <= RUN;
        RUN:     if (halt_i || oob) state_q <= HALTED;
        HALTED:  if (start_i && !fault_q) state_q <= RUN;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction fetch sequencer for the core's instruction memory.
- Instruction memory is a word array, combinational read, word index = addr>>2.
- Block owns the PC, drives the memory address, and registers the returned word into a one-entry valid/ready output stage toward decode.
- Handles start, halt, redirect (branch/jump) and back-pressure.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- MEM_WORDS, 301, instruction memory depth in words; used by bounds check.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start_i  input  1  leave IDLE/HALTED and begin fetching.
- halt_i  input  1  stop issuing new fetches.
- redirect_i  input  1  load new PC and flush the output stage.
- redirect_pc_i  input  32  target byte address.
- imem_addr_o  output  32  byte address to instruction memory.
- imem_rdata_i  input  32  instruction word, valid in the same cycle as imem_addr_o.
- inst_o  output  32  registered instruction to decode.
- pc_o  output  32  byte address of inst_o.
- valid_o  output  1  inst_o/pc_o hold a valid instruction.
- ready_i  input  1  decode accepts inst_o this cycle.
- busy_o  output  1  high in RUN state.
- fetch_cnt_o  output  32  number of instructions handed off (valid_o && ready_i).
- fault_o  output  1  sticky out-of-range fault (optional feature; tied 0 otherwise).

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE, pc_q=RESET_PC, valid_o=0, inst_o=0, pc_o=0, fetch_cnt_o=0, fault_o=0.
  - Overrides every other input.
- imem_addr_o = pc_q at all times (combinational from register).
- Load condition: load = (state==RUN) && (!valid_o || ready_i).
  - On load: inst_o<=imem_rdata_i, pc_o<=pc_q, valid_o<=1, pc_q<=pc_q+PC_STEP.
  - PC addition wraps modulo 2^32.
- Hold: valid_o && !ready_i leaves inst_o, pc_o, valid_o and pc_q unchanged.
- Drain: valid_o && ready_i with no load gives valid_o<=0.
- Throughput and latency: one instruction per cycle when ready_i is held high. First valid_o is 1 cycle after entering RUN.
- FSM:
  - IDLE: start_i -> RUN. No fetch in IDLE.
  - RUN:
    - halt_i -> HALTED. The halt cycle issues no load. A pending valid_o stays until accepted.
    - redirect_i -> stays RUN.
  - HALTED: start_i -> RUN, resuming from current pc_q. redirect_i updates pc_q but stays HALTED.
- Redirect (any state):
  - pc_q <= {redirect_pc_i[31:2],2'b00}; low bits are forced 0.
  - valid_o<=0; the flush wins over hold and over load.
  - Next fetch, if RUN, uses the new PC one cycle later.
- Priority in RUN: redirect_i > halt_i > load.
  - redirect_i && halt_i in the same cycle: pc_q redirected, valid_o flushed, state -> HALTED.
- Counter: fetch_cnt_o increments on every cycle with valid_o && ready_i, including a cycle where a redirect flushes. Wraps 32'hFFFF_FFFF -> 0.
- busy_o = (state==RUN).
- start_i in RUN is ignored.
- rst asserted mid-stream: next cycle shows the full reset state; any in-flight instruction is discarded.

Optional Feature:
- Macro FETCH_BOUNDS_CHECK_EN.
- Defined:
  - If a load would occur with (pc_q>>2) >= MEM_WORDS, the load is suppressed, fault_o<=1 (sticky), and state -> HALTED.
  - While fault_o=1, start_i is ignored; only rst clears fault_o.
  - Redirect still updates pc_q.
- Undefined:
  - No check; the address passes through unchecked.
  - fault_o is constant 0.

Test Plan:
- Reset, start_i pulse, ready_i=1, memory holds word k = 32'h1000_0000+k -> valid_o high from cycle 1; pc_o = 0,4,8,12; inst_o = 32'h1000_0000..3; fetch_cnt_o = 4 after 4 handoffs.
- Back-pressure: ready_i=0 for 3 cycles at pc_o=8 -> inst_o/pc_o held at 8, imem_addr_o stays 12, fetch_cnt_o frozen; on ready_i=1 the next pc_o=12, with no skip and no duplicate.
- Redirect: redirect_i with redirect_pc_i=32'h0000_0043 while valid_o=1, ready_i=1 -> next cycle valid_o=0, imem_addr_o=32'h40, fetch_cnt_o incremented once; following cycle pc_o=32'h40.
- Halt then resume: halt_i at pc_q=16 -> busy_o=0, pending instruction drains; start_i -> fetch resumes with pc_o=16. Same-cycle halt_i+redirect_i to 32'h80 -> HALTED, pc_q=32'h80.
- Reset mid-stream: rst for 1 cycle while valid_o=1 -> valid_o=0, pc_q=RESET_PC, fetch_cnt_o=0, state IDLE, start_i required again.
- With FETCH_BOUNDS_CHECK_EN, MEM_WORDS=4: run from 0 -> 4 instructions delivered; at pc_q=16, fault_o=1, state HALTED, start_i ignored. Without the macro: pc_o=16 is delivered and fault_o stays 0.
